reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Single-clock reset sequencer generalising per-domain registered resetn fan-out.
//  Drives NCH reset channels, each replicated FANOUT bits wide to ease timing.
//  Releases channels in index order with programmable hold and inter-stage delay.
//  Supports masked software re-sequencing and counts completed sequences.
// PARAMETERS
//  NCH     4   number of reset channels (>=1)
//  FANOUT  32  replicated resetn bits per channel
//  CNTW    16  width of hold/dly counters
//  SYNCW   2   areset deassertion synchroniser depth (>=2)
// PORTS
//  clk         in   1            sequencer clock
//  areset      in   1            async active-high reset; assert async, deassert sync via SYNCW flops
//  sw_reset    in   1            sync request; rising edge starts a masked sequence
//  ch_mask     in   NCH          channels included in a sw_reset sequence
//  hold        in   CNTW         cycles all active channels stay asserted (0 treated as 1)
//  dly         in   CNTW         extra cycles between successive channel releases
//  reset_out   out  NCH          active-high reset per channel, registered
//  resetn_out  out  NCH*FANOUT   {FANOUT{~reset_out[i]}} at [i*FANOUT+:FANOUT], one extra flop
//  busy        out  1            sequence in progress
//  done        out  1            all channels released, idle
//  seq_count   out  16           completed sequences, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (areset=1, async): reset_out=all 1, resetn_out=all 0, busy=1, done=0,
//   seq_count=0, FSM=WAIT, active set=all channels. Sync chain presets to 1.
//  FSM: WAIT -> HOLD -> REL -> DONE; DONE -> HOLD on accepted sw_reset.
//  WAIT: until synchroniser output is 0; then latch hold,dly, load hold counter -> HOLD.
//   T0 := first cycle in HOLD.
//  HOLD: active channels asserted; stays max(hold,1) cycles; then idx=0, load dly -> REL.
//  REL: counter down to 0; at 0, clear reset_out[idx] if idx in active set, idx++,
//   reload dly. Masked-out channel slots still consume dly+1 cycles (fixed timing).
//   reset_out[k] falls at edge T0+max(hold,1)+k*(dly+1)+dly.
//   After idx=NCH-1 released -> DONE next edge; done=1, busy=0, seq_count+=1.
//  resetn_out[k] rises exactly one clk after reset_out[k] falls (both registered).
//  DONE: sw_reset rising edge (registered edge detect, 1-cycle latency) with
//   ch_mask!=0: active set=ch_mask, relatch hold,dly, assert reset_out for active
//   channels, busy=1, done=0 -> HOLD. Non-active channels untouched, never glitch.
//   ch_mask==0: request ignored, stays DONE.
//  sw_reset edges in WAIT/HOLD/REL ignored (not queued); sw_reset held high starts once.
//  hold/dly/ch_mask changes mid-sequence have no effect (latched at start).
//  areset mid-sequence: immediate async return to reset values; full sequence
//   with all channels after deassertion; seq_count cleared.
//  dly=0: one channel per cycle. Counter widths CNTW; no overflow (loaded, counts down).
// TESTING
//  1 NCH=4,SYNCW=2,hold=3,dly=2, release areset -> reset_out[0..3] fall at T0+5,+8,+11,+14;
//    resetn_out each 1 cycle later, all FANOUT bits equal; done=1,seq_count=1 at T0+15.
//  2 hold=0,dly=0 -> reset_out[k] falls at T0+1+k; done at T0+1+NCH.
//  3 In DONE, sw_reset pulse, ch_mask=4'b0101 -> only ch0,ch2 reassert; ch1,ch3
//    stay 0 throughout; ch2 still released in slot 2 timing; seq_count=2.
//  4 sw_reset with ch_mask=0, and sw_reset pulses during REL -> no state change,
//    seq_count unchanged, no extra sequence afterwards.
//  5 Assert areset at T0+9 (mid-REL) -> same-cycle async: reset_out=all 1,
//    resetn_out=0, seq_count=0; deassert -> clean full sequence as test 1.
//  6 seq_count preset path: run 65536 sw sequences (or force) -> wraps to 0, no glitch.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NCH reset channels in index order after a
// programmable hold, spacing releases by a programmable delay. Each channel
// drives a registered active-high reset and a FANOUT-wide registered resetn.
module reset_sequencer #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned FANOUT = 32,
  parameter int unsigned CNTW   = 16,
  parameter int unsigned SYNCW  = 2
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    sw_reset,
  input  logic [NCH-1:0]          ch_mask,
  input  logic [CNTW-1:0]         hold,
  input  logic [CNTW-1:0]         dly,
  output logic [NCH-1:0]          reset_out,
  output logic [NCH*FANOUT-1:0]   resetn_out,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             seq_count
);

  localparam int unsigned IDXW = $clog2(NCH + 1);

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_REL, S_DONE} state_t;

  state_t           state, state_d;
  logic [SYNCW-1:0] sync;
  logic             sync_out;
  logic             sw_d, sw_rise;
  logic [CNTW-1:0]  cnt, cnt_d;
  logic [CNTW-1:0]  dly_l, dly_l_d;
  logic [CNTW-1:0]  hold_m1;
  logic [IDXW-1:0]  idx, idx_d;
  logic [NCH-1:0]   active, active_d;
  logic [NCH-1:0]   rst_d;
  logic             busy_d, done_d;
  logic [15:0]      count_d;

  assign sync_out = sync[SYNCW-1];
  assign hold_m1  = (hold == '0) ? '0 : hold - CNTW'(1);

  // areset deassertion synchroniser, presets to 1 so release is clean
  always_ff @(posedge clk or posedge areset) begin
    if (areset) sync <= '1;
    else        sync <= {sync[SYNCW-2:0], 1'b0};
  end

  // registered rising-edge detect on the software request
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sw_d    <= 1'b0;
      sw_rise <= 1'b0;
    end else begin
      sw_d    <= sw_reset;
      sw_rise <= sw_reset & ~sw_d;
    end
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= S_WAIT;
      cnt       <= '0;
      dly_l     <= '0;
      idx       <= '0;
      active    <= '1;
      reset_out <= '1;
      busy      <= 1'b1;
      done      <= 1'b0;
      seq_count <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      dly_l     <= dly_l_d;
      idx       <= idx_d;
      active    <= active_d;
      reset_out <= rst_d;
      busy      <= busy_d;
      done      <= done_d;
      seq_count <= count_d;
    end
  end

  // next-state and output decode
  // A release takes effect on the edge that ends the cycle where the slot
  // counter reads 0, so the first slot is loaded with dly-1 on leaving HOLD,
  // and with dly==0 channel 0 is released on that same edge.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    dly_l_d  = dly_l;
    idx_d    = idx;
    active_d = active;
    rst_d    = reset_out;
    busy_d   = busy;
    done_d   = done;
    count_d  = seq_count;
    unique case (state)
      S_WAIT: begin
        if (!sync_out) begin
          dly_l_d = dly;
          cnt_d   = hold_m1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          if (dly_l == '0) begin
            if (active[0]) rst_d[0] = 1'b0;
            idx_d = IDXW'(1);
            cnt_d = '0;
          end else begin
            idx_d = '0;
            cnt_d = dly_l - CNTW'(1);
          end
          state_d = S_REL;
        end else begin
          cnt_d = cnt - CNTW'(1);
        end
      end
      S_REL: begin
        if (idx == IDXW'(NCH)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          count_d = seq_count + 16'd1;
        end else if (cnt == '0) begin
          for (int unsigned k = 0; k < NCH; k++) begin
            if ((idx == IDXW'(k)) && active[k]) rst_d[k] = 1'b0;
          end
          idx_d = idx + IDXW'(1);
          cnt_d = dly_l;
        end else begin
          cnt_d = cnt - CNTW'(1);
        end
      end
      S_DONE: begin
        if (sw_rise && (ch_mask != '0)) begin
          active_d = ch_mask;
          dly_l_d  = dly;
          cnt_d    = hold_m1;
          rst_d    = reset_out | ch_mask;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          state_d  = S_HOLD;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // replicated active-low fan-out, one flop behind reset_out
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      resetn_out <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        resetn_out[k*FANOUT +: FANOUT] <= {FANOUT{~reset_out[k]}};
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed release-timing table, hand-written
// corner sequences, then random stimulus against a timeline reference model.
module tb_reset_sequencer;

  localparam int unsigned NCH    = 4;
  localparam int unsigned FANOUT = 32;
  localparam int unsigned CNTW   = 16;
  localparam int unsigned SYNCW  = 2;
  localparam int unsigned W      = NCH * FANOUT;

  logic              clk = 1'b0;
  logic              areset;
  logic              sw_reset;
  logic [NCH-1:0]    ch_mask;
  logic [CNTW-1:0]   hold;
  logic [CNTW-1:0]   dly;
  logic [NCH-1:0]    reset_out;
  logic [W-1:0]      resetn_out;
  logic              busy;
  logic              done;
  logic [15:0]       seq_count;

  int errors = 0;
  int checks = 0;

  reset_sequencer #(
    .NCH(NCH), .FANOUT(FANOUT), .CNTW(CNTW), .SYNCW(SYNCW)
  ) dut (
    .clk(clk), .areset(areset), .sw_reset(sw_reset), .ch_mask(ch_mask),
    .hold(hold), .dly(dly), .reset_out(reset_out), .resetn_out(resetn_out),
    .busy(busy), .done(done), .seq_count(seq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fan(input logic [NCH-1:0] r);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*FANOUT +: FANOUT] = {FANOUT{~r[k]}};
    return v;
  endfunction

  // Reference model: a sequence is a timeline from T0; channel k of the
  // active set is low from T0 + H + k*(D+1) + D, done one cycle after the last.
  typedef enum {P_WAIT, P_RUN, P_DONE} phase_t;
  phase_t         m_phase;
  int             m_edges, m_t, m_h, m_d;
  logic [NCH-1:0] m_rst, m_active;
  logic [W-1:0]   m_rn;
  logic [15:0]    m_count;
  logic           m_swprev, m_pulse;

  function automatic int fall_of(input int k);
    return m_h + k * (m_d + 1) + m_d;
  endfunction

  task automatic model_reset();
    m_phase = P_WAIT; m_edges = 0; m_t = 0; m_h = 1; m_d = 0;
    m_rst = '1; m_active = '1; m_rn = '0; m_count = '0;
    m_swprev = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_start(input logic [NCH-1:0] mask);
    m_active = mask;
    m_h      = (hold == '0) ? 1 : int'(hold);
    m_d      = int'(dly);
    m_t      = 0;
    m_rst    = m_rst | mask;
    m_phase  = P_RUN;
  endtask

  task automatic model_edge();
    logic pulse_now;
    m_rn      = fan(m_rst);
    pulse_now = m_pulse;
    m_pulse   = sw_reset && !m_swprev;
    m_swprev  = sw_reset;
    case (m_phase)
      P_WAIT: begin
        m_edges++;
        if (m_edges == SYNCW + 1) model_start('1);
      end
      P_RUN: begin
        m_t++;
        for (int k = 0; k < NCH; k++) if (m_active[k]) m_rst[k] = (m_t < fall_of(k));
        if (m_t == fall_of(NCH - 1) + 1) begin
          m_phase = P_DONE;
          m_count = m_count + 16'd1;
        end
      end
      default: if (pulse_now && ch_mask != '0) model_start(ch_mask);
    endcase
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_reset_out"},  W'(reset_out), W'(m_rst));
    chk({tag, "_resetn_out"}, resetn_out, m_rn);
    chk({tag, "_busy"},       W'(busy), W'(m_phase != P_DONE));
    chk({tag, "_done"},       W'(done), W'(m_phase == P_DONE));
    chk({tag, "_seq_count"},  W'(seq_count), W'(m_count));
  endtask

  // every clock advance goes through here so the model stays aligned
  task automatic tick();
    @(posedge clk);
    if (!areset) model_edge();
    #1;
  endtask

  task automatic assert_areset();
    #3;
    areset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_reset_out"},  W'(reset_out), W'(4'b1111));
    chk({tag, "_resetn_out"}, resetn_out, '0);
    chk({tag, "_busy"},       W'(busy), W'(1'b1));
    chk({tag, "_done"},       W'(done), W'(1'b0));
    chk({tag, "_seq_count"},  W'(seq_count), '0);
  endtask

  // observation of one sequence: n counts edges from the first measured tick
  int             meas_fall[NCH];
  int             meas_done;
  bit             meas_glitch, meas_track;
  logic [NCH-1:0] meas_first;

  task automatic measure(input logic [NCH-1:0] mask, input int nmax, input bit sw_start);
    logic [NCH-1:0] prev;
    bit seen_low;
    prev = reset_out;
    seen_low = 1'b0;
    for (int k = 0; k < NCH; k++) meas_fall[k] = -1;
    meas_done = -1; meas_glitch = 1'b0; meas_track = 1'b0; meas_first = '0;
    for (int n = 1; n <= nmax; n++) begin
      tick();
      if (n == 1 && sw_start) sw_reset = 1'b0;
      if (n == 2) meas_first = reset_out;
      if (resetn_out !== fan(prev)) meas_track = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (prev[k] === 1'b1 && reset_out[k] === 1'b0 && meas_fall[k] < 0) meas_fall[k] = n;
        if (!mask[k] && reset_out[k] !== 1'b0) meas_glitch = 1'b1;
      end
      if (done === 1'b0) seen_low = 1'b1;
      else if (done === 1'b1 && seen_low && meas_done < 0) meas_done = n;
      if (n == 3) begin
        hold    = CNTW'($urandom_range(0, 9));
        dly     = CNTW'($urandom_range(0, 9));
        ch_mask = NCH'($urandom);
      end
      prev = reset_out;
      if (meas_done > 0 && n >= meas_done + 2) break;
    end
  endtask

  task automatic check_meas(input string tag, input logic [NCH-1:0] mask,
                            input int f0, input int f1, input int f2, input int f3,
                            input int dn, input logic [15:0] cnt);
    int ef[NCH];
    ef[0] = f0; ef[1] = f1; ef[2] = f2; ef[3] = f3;
    for (int k = 0; k < NCH; k++) chk($sformatf("%s_fall%0d", tag, k), W'(meas_fall[k]), W'(ef[k]));
    chk({tag, "_done_time"}, W'(meas_done), W'(dn));
    chk({tag, "_assert"},    W'(meas_first), W'(mask));
    chk({tag, "_glitch"},    W'(meas_glitch), '0);
    chk({tag, "_resetn_lag"}, W'(meas_track), '0);
    chk({tag, "_seq_count"}, W'(seq_count), W'(cnt));
    chk({tag, "_busy"},      W'(busy), W'(1'b0));
  endtask

  typedef struct {
    logic [CNTW-1:0] h;
    logic [CNTW-1:0] d;
    logic [NCH-1:0]  m;
    int f0, f1, f2, f3;
    int dn;
  } vec_t;

  initial begin
    vec_t        vt[5];
    logic [15:0] exp_cnt;
    int          dn;
    bit          busy_after;

    // n measured from the edge that samples sw_reset high; T0 is n=2
    vt[0] = '{16'd3, 16'd2, 4'b1111,  7, 10, 13, 16, 17};
    vt[1] = '{16'd0, 16'd0, 4'b1111,  3,  4,  5,  6,  7};
    vt[2] = '{16'd1, 16'd0, 4'b0101,  3, -1,  5, -1,  7};
    vt[3] = '{16'd2, 16'd3, 4'b1000, -1, -1, -1, 19, 20};
    vt[4] = '{16'd5, 16'd1, 4'b0110, -1, 10, 12, -1, 15};

    areset = 1'b1; sw_reset = 1'b0; ch_mask = '0; hold = 16'd3; dly = 16'd2;
    model_reset();
    repeat (3) tick();
    check_reset_values("por");

    // release from areset: T0 is the third edge after deassertion (n=3)
    #2 areset = 1'b0;
    measure('1, 40, 1'b0);
    exp_cnt = 16'd1;
    check_meas("arst_seq", '1, 8, 11, 14, 17, 18, exp_cnt);

    for (int i = 0; i < 5; i++) begin
      hold = vt[i].h; dly = vt[i].d; ch_mask = vt[i].m;
      sw_reset = 1'b1;
      measure(vt[i].m, 40, 1'b1);
      exp_cnt = exp_cnt + 16'd1;
      check_meas($sformatf("vec%0d", i), vt[i].m, vt[i].f0, vt[i].f1, vt[i].f2, vt[i].f3,
                 vt[i].dn, exp_cnt);
    end

    // empty mask request is ignored
    ch_mask = '0; sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    repeat (8) tick();
    chk("mask0_done", W'(done), W'(1'b1));
    chk("mask0_busy", W'(busy), W'(1'b0));
    chk("mask0_reset_out", W'(reset_out), '0);
    chk("mask0_seq_count", W'(seq_count), W'(exp_cnt));

    // requests during a running sequence, then held high, start nothing more
    hold = 16'd2; dly = 16'd3; ch_mask = '1; sw_reset = 1'b1;
    tick();
    sw_reset = 1'b0;
    dn = -1; busy_after = 1'b0;
    for (int n = 2; n <= 60; n++) begin
      tick();
      if (n == 6) sw_reset = 1'b1;
      if (n == 7) sw_reset = 1'b0;
      if (n == 10) sw_reset = 1'b1;
      if (dn < 0 && done === 1'b1) dn = n;
      else if (dn > 0 && busy !== 1'b0) busy_after = 1'b1;
      if (dn > 0 && n >= dn + 15) break;
    end
    exp_cnt = exp_cnt + 16'd1;
    chk("ignore_done_time", W'(dn), W'(20));
    chk("ignore_no_restart", W'(busy_after), '0);
    chk("ignore_seq_count", W'(seq_count), W'(exp_cnt));
    chk("ignore_reset_out", W'(reset_out), '0);
    sw_reset = 1'b0;
    tick();

    // areset in the middle of the release phase
    hold = 16'd3; dly = 16'd2;
    assert_areset();
    check_reset_values("arst1");
    #2 areset = 1'b0;
    for (int n = 1; n <= 12; n++) tick();
    chk("midrel_reset_out", W'(reset_out), W'(4'b1100));
    assert_areset();
    check_reset_values("arst_midrel");
    #2 areset = 1'b0;
    measure('1, 40, 1'b0);
    check_meas("arst_reseq", '1, 8, 11, 14, 17, 18, 16'd1);

    // random stimulus against the timeline model
    check_model("pre_rnd");
    for (int i = 0; i < 3000; i++) begin
      sw_reset = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        hold    = CNTW'($urandom_range(0, 4));
        dly     = CNTW'($urandom_range(0, 3));
        ch_mask = NCH'($urandom);
      end
      if ($urandom_range(0, 399) == 0) begin
        assert_areset();
        check_model("rnd_arst");
        #2 areset = 1'b0;
      end
      tick();
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
